// File: rtl/rtc_bus_responder.sv
// RTC bus responder: runs multi-byte register reads/writes on the RTC muxed
// address/data bus for Status3bit commands. Optional BCD check: RTC_BCD_CHECK_EN.
module rtc_bus_responder #(
  parameter int unsigned PULSE = 4
) (
  input  logic        reloj,
  input  logic        resetM,
  input  logic [2:0]  Status3bit,
  input  logic [23:0] dato_in,
  input  logic [7:0]  ad_in,
  output logic        sync,
  output logic        busy,
  output logic [23:0] dato_out,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        a_d,
  output logic        bcd_err
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 2;
  localparam int unsigned CMD_W  = 3;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned BUS_W  = 8;

  localparam logic [CMD_W-1:0] CMD_IDLE = 3'b000;
  localparam logic [CMD_W-1:0] CMD_XFER = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_SETUP,
    S_ADDR_STROBE,
    S_ADDR_HOLD,
    S_DATA_SETUP,
    S_DATA_STROBE,
    S_DATA_HOLD,
    S_GAP,
    S_DONE,
    S_WAIT_REL
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dato_out_q, dato_out_d;

  logic                sync_q, sync_d;
  logic                busy_q, busy_d;
  logic [BUS_W-1:0]    ad_out_q, ad_out_d;
  logic                ad_oe_q, ad_oe_d;
  logic                cs_n_q, cs_n_d;
  logic                rd_n_q, rd_n_d;
  logic                wr_n_q, wr_n_d;
  logic                a_d_q, a_d_d;

  logic                strobe_last;
  logic                last_byte;
  logic                is_write_d;
  logic [BUS_W-1:0]    addr_d;
  logic [BUS_W-1:0]    wbyte_d;

`ifdef RTC_BCD_CHECK_EN
  logic                bcd_err_q, bcd_err_d;
`endif

  assign strobe_last = (cnt_q == CNT_W'(PULSE - 1));
  assign last_byte   = (byte_q == ((cmd_q == CMD_XFER) ? BYTE_W'(0) : BYTE_W'(2)));

  // Sequencing: command latch, phase timing, byte stepping and read capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    dato_out_d = dato_out_q;
`ifdef RTC_BCD_CHECK_EN
    bcd_err_d  = bcd_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (Status3bit != CMD_IDLE) begin
          state_d = S_ADDR_SETUP;
          cmd_d   = Status3bit;
          wdata_d = dato_in;
          byte_d  = '0;
`ifdef RTC_BCD_CHECK_EN
          bcd_err_d = 1'b0;
`endif
        end
      end
      S_ADDR_SETUP: begin
        state_d = S_ADDR_STROBE;
        cnt_d   = '0;
      end
      S_ADDR_STROBE: begin
        if (strobe_last) state_d = S_ADDR_HOLD;
        else             cnt_d   = cnt_q + CNT_W'(1);
      end
      S_ADDR_HOLD: state_d = S_DATA_SETUP;
      S_DATA_SETUP: begin
        state_d = S_DATA_STROBE;
        cnt_d   = '0;
      end
      S_DATA_STROBE: begin
        if (strobe_last) begin
          state_d = S_DATA_HOLD;
          if (!cmd_q[2]) begin
            unique case (byte_q)
              2'd0:    dato_out_d[7:0]   = ad_in;
              2'd1:    dato_out_d[15:8]  = ad_in;
              default: dato_out_d[23:16] = ad_in;
            endcase
`ifdef RTC_BCD_CHECK_EN
            if ((ad_in[7:4] > 4'd9) || (ad_in[3:0] > 4'd9)) bcd_err_d = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA_HOLD: begin
        if (last_byte) begin
          state_d = S_DONE;
        end else begin
          state_d = S_GAP;
          byte_d  = byte_q + BYTE_W'(1);
        end
      end
      S_GAP:      state_d = S_ADDR_SETUP;
      S_DONE:     state_d = (Status3bit == CMD_IDLE) ? S_IDLE : S_WAIT_REL;
      S_WAIT_REL: if (Status3bit == CMD_IDLE) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the registers line up with it
  always_comb begin
    is_write_d = cmd_d[2];
    unique case (cmd_d)
      3'b001, 3'b100: addr_d = 8'h21 + BUS_W'(byte_d);
      3'b010, 3'b101: addr_d = 8'h24 + BUS_W'(byte_d);
      3'b011, 3'b110: addr_d = 8'h41 + BUS_W'(byte_d);
      3'b111:         addr_d = 8'hF0;
      default:        addr_d = 8'h00;
    endcase
    if (cmd_d == CMD_XFER) begin
      wbyte_d = 8'hF0;
    end else begin
      unique case (byte_d)
        2'd0:    wbyte_d = wdata_d[7:0];
        2'd1:    wbyte_d = wdata_d[15:8];
        default: wbyte_d = wdata_d[23:16];
      endcase
    end

    sync_d   = 1'b0;
    busy_d   = (state_d != S_IDLE) && (state_d != S_WAIT_REL);
    ad_out_d = '0;
    ad_oe_d  = 1'b0;
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    a_d_d    = 1'b0;
    unique case (state_d)
      S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD: begin
        cs_n_d   = 1'b0;
        a_d_d    = 1'b1;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = (state_d != S_ADDR_STROBE);
      end
      S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = is_write_d;
        ad_out_d = is_write_d ? wbyte_d : 8'h00;
        if (state_d == S_DATA_STROBE) begin
          wr_n_d = !is_write_d;
          rd_n_d = is_write_d;
        end
      end
      S_DONE:  sync_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      cmd_q      <= '0;
      wdata_q    <= '0;
      dato_out_q <= '0;
      sync_q     <= 1'b0;
      busy_q     <= 1'b0;
      ad_out_q   <= '0;
      ad_oe_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      a_d_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      dato_out_q <= dato_out_d;
      sync_q     <= sync_d;
      busy_q     <= busy_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      a_d_q      <= a_d_d;
    end
  end

`ifdef RTC_BCD_CHECK_EN
  always_ff @(posedge reloj) begin
    if (resetM) bcd_err_q <= 1'b0;
    else        bcd_err_q <= bcd_err_d;
  end
  assign bcd_err = bcd_err_q;
`else
  assign bcd_err = 1'b0;
`endif

  assign sync     = sync_q;
  assign busy     = busy_q;
  assign dato_out = dato_out_q;
  assign ad_out   = ad_out_q;
  assign ad_oe    = ad_oe_q;
  assign cs_n     = cs_n_q;
  assign rd_n     = rd_n_q;
  assign wr_n     = wr_n_q;
  assign a_d      = a_d_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with a small RTC register-file bus model.
module tb_rtc_bus_responder;

  logic        reloj = 1'b0;
  logic        resetM;
  logic [2:0]  Status3bit;
  logic [23:0] dato_in;
  logic [7:0]  ad_in;
  logic        sync, busy, ad_oe, cs_n, rd_n, wr_n, a_d, bcd_err;
  logic [23:0] dato_out;
  logic [7:0]  ad_out;

`ifdef RTC_BCD_CHECK_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  localparam logic [39:0] RST_VAL = {1'b0, 1'b0, 24'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  always #5 reloj = ~reloj;

  rtc_bus_responder #(.PULSE(4)) dut (
    .reloj(reloj), .resetM(resetM), .Status3bit(Status3bit), .dato_in(dato_in),
    .ad_in(ad_in), .sync(sync), .busy(busy), .dato_out(dato_out), .ad_out(ad_out),
    .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d), .bcd_err(bcd_err)
  );

  // RTC model: address latched on the address strobe, data written/read at that address
  logic [7:0] mem [0:255];
  logic [7:0] last_addr = 8'h00;

  always @(posedge reloj) begin
    if (!cs_n && a_d && !wr_n)  last_addr <= ad_out;
    if (!cs_n && !a_d && !wr_n) mem[last_addr] <= ad_out;
  end
  assign ad_in = (!rd_n) ? mem[last_addr] : 8'h00;

  logic [8:0] wlog [$];
  logic       wr_n_prev = 1'b1;
  int         overlap_cnt = 0;
  int         oe_read_err = 0;
  int         rd_cycles   = 0;

  always @(negedge reloj) begin
    if (!rd_n && !wr_n) overlap_cnt++;
    if (!rd_n && ad_oe) oe_read_err++;
    if (!rd_n) rd_cycles++;
    if (!wr_n && wr_n_prev) wlog.push_back({a_d, ad_out});
    wr_n_prev = wr_n;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] outs();
    return {sync, busy, dato_out, ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, bcd_err};
  endfunction

  logic        busy_tr [0:199];
  logic        bcd_tr  [0:199];
  int          first_sync;
  int          n_sync;
  logic [23:0] sync_dout;

  // Issue a command right after a negedge; cycle k is sampled at the k-th following negedge
  task automatic run_cmd(input logic [2:0] cmd, input logic [23:0] din,
                         input int hold, input int ncyc);
    first_sync = 0;
    n_sync     = 0;
    sync_dout  = 24'h0;
    Status3bit = cmd;
    dato_in    = din;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge reloj);
      busy_tr[k] = busy;
      bcd_tr[k]  = bcd_err;
      if (sync) begin
        if (n_sync == 0) begin
          first_sync = k;
          sync_dout  = dato_out;
        end
        n_sync++;
      end
      if (k == 1) dato_in = 24'hFFFFFF;
      if (k == hold) Status3bit = 3'b000;
    end
  endtask

  int idle_bad;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    resetM     = 1'b1;
    Status3bit = 3'b000;
    dato_in    = 24'h0;
    repeat (10) @(negedge reloj);
    check("reset_outs", 64'(outs()), 64'(RST_VAL));

    resetM   = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge reloj);
      if (outs() !== RST_VAL) idle_bad++;
    end
    check("idle_outs", 64'(idle_bad), 64'd0);
    check("idle_no_writes", 64'(wlog.size()), 64'd0);

    // Write time, command dropped mid-transaction
    wlog.delete();
    run_cmd(3'b100, 24'h110001, 10, 45);
    check("wt_sync_cycle", 64'(first_sync), 64'd39);
    check("wt_sync_count", 64'(n_sync), 64'd1);
    check("wt_busy_c1", 64'(busy_tr[1]), 64'd1);
    check("wt_busy_c39", 64'(busy_tr[39]), 64'd1);
    check("wt_busy_c40", 64'(busy_tr[40]), 64'd0);
    check("wt_log_size", 64'(wlog.size()), 64'd6);
    check("wt_log0", 64'(wlog[0]), 64'h121);
    check("wt_log1", 64'(wlog[1]), 64'h001);
    check("wt_log2", 64'(wlog[2]), 64'h122);
    check("wt_log3", 64'(wlog[3]), 64'h000);
    check("wt_log4", 64'(wlog[4]), 64'h123);
    check("wt_log5", 64'(wlog[5]), 64'h011);
    check("wt_dato_out", 64'(dato_out), 64'h0);

    // Read time
    mem[8'h21] = 8'h45;
    mem[8'h22] = 8'h30;
    mem[8'h23] = 8'h12;
    rd_cycles  = 0;
    run_cmd(3'b001, 24'hABCDEF, 1000, 45);
    Status3bit = 3'b000;
    repeat (2) @(negedge reloj);
    check("rt_sync_cycle", 64'(first_sync), 64'd39);
    check("rt_dato_at_sync", 64'(sync_dout), 64'h123045);
    check("rt_oe_in_read", 64'(oe_read_err), 64'd0);
    check("rt_rd_cycles", 64'(rd_cycles), 64'd12);
    check("rt_bcd_ok", 64'(bcd_err), 64'd0);

    // Transfer command held for 100 cycles
    wlog.delete();
    run_cmd(3'b111, 24'h0, 1000, 100);
    check("xf_sync_cycle", 64'(first_sync), 64'd13);
    check("xf_sync_count", 64'(n_sync), 64'd1);
    check("xf_busy_c14", 64'(busy_tr[14]), 64'd0);
    check("xf_log_size", 64'(wlog.size()), 64'd2);
    check("xf_log0", 64'(wlog[0]), 64'h1F0);
    check("xf_log1", 64'(wlog[1]), 64'h0F0);
    check("xf_dato_kept", 64'(dato_out), 64'h123045);
    Status3bit = 3'b000;
    repeat (2) @(negedge reloj);

    // Reset in the middle of a date read
    mem[8'h24] = 8'h07;
    mem[8'h25] = 8'h15;
    mem[8'h26] = 8'h23;
    Status3bit = 3'b010;
    repeat (20) @(negedge reloj);
    resetM     = 1'b1;
    Status3bit = 3'b000;
    @(negedge reloj);
    check("mid_reset_outs", 64'(outs()), 64'(RST_VAL));
    resetM = 1'b0;
    @(negedge reloj);
    run_cmd(3'b010, 24'h0, 1000, 45);
    Status3bit = 3'b000;
    repeat (2) @(negedge reloj);
    check("rd_date_sync_cycle", 64'(first_sync), 64'd39);
    check("rd_date_data", 64'(sync_dout), 64'h231507);

    // Non-BCD read byte, then the flag clears on the next acceptance
    mem[8'h21] = 8'h3A;
    mem[8'h22] = 8'h11;
    mem[8'h23] = 8'h22;
    run_cmd(3'b001, 24'h0, 1000, 45);
    check("bcd_read_data", 64'(sync_dout), 64'h22113A);
    check("bcd_after_sync", 64'(bcd_err), 64'(BCD_ON));
    Status3bit = 3'b000;
    repeat (2) @(negedge reloj);
    check("bcd_held_idle", 64'(bcd_err), 64'(BCD_ON));
    run_cmd(3'b010, 24'h0, 1000, 45);
    check("bcd_clear_c1", 64'(bcd_tr[1]), 64'd0);
    check("bcd_clear_end", 64'(bcd_err), 64'd0);
    Status3bit = 3'b000;
    repeat (2) @(negedge reloj);

    check("no_strobe_overlap", 64'(overlap_cnt), 64'd0);
    check("no_oe_during_read", 64'(oe_read_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Executes the RTC register transactions that the general control machine requests. It takes the 3-bit command on `Status3bit` and runs the matching multi-byte read or write on the RTC's multiplexed address/data bus. When the transaction finishes it returns a one-cycle `sync` pulse. It is the responder end of the `Status3bit`/`sync` handshake and owns all RTC bus strobes.

## Interface
- `PULSE`, default 4, number of cycles each strobe (`rd_n`/`wr_n`) stays low; legal range 1..15.
- `reloj` input 1: system clock; every register updates on its rising edge.
- `resetM` input 1: reset, synchronous, active-high.
- `Status3bit` input 3: command from the control machine; 000 means idle.
- `dato_in` input 24: write data; [7:0] goes to the first register, [15:8] to the second, [23:16] to the third.
- `ad_in` input 8: bus read data, coming from the top-level tristate pad.
- `sync` output 1: one-cycle done pulse.
- `busy` output 1: high from command acceptance until `sync` inclusive.
- `dato_out` output 24: read data, using the same byte order as `dato_in`.
- `ad_out` output 8: bus drive value.
- `ad_oe` output 1: pad output enable.
- `cs_n`, `rd_n`, `wr_n` output 1 each: active-low bus strobes.
- `a_d` output 1: 1 during an address phase, 0 during a data phase.
- `bcd_err` output 1: BCD check flag (see Configuration).

## Operation
- Command map:
  - 001: read time, addresses 21h/22h/23h.
  - 010: read date, addresses 24h/25h/26h.
  - 011: read timer, addresses 41h/42h/43h.
  - 100: write time, addresses 21h/22h/23h.
  - 101: write date, addresses 24h/25h/26h.
  - 110: write timer, addresses 41h/42h/43h.
  - 111: transfer command, a single write of data F0h to address F0h.
- States: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, GAP, DONE, WAIT_REL.
- IDLE: a nonzero `Status3bit` is latched, together with `dato_in`, and the machine moves to ADDR_SETUP. `Status3bit` and `dato_in` are ignored afterwards until the next acceptance.
- Address phase for each byte:
  - ADDR_SETUP: 1 cycle.
  - ADDR_STROBE: `PULSE` cycles, with `wr_n` low.
  - ADDR_HOLD: 1 cycle.
  - `a_d` = 1, `ad_oe` = 1, `ad_out` = the address.
- Data phase for each byte:
  - DATA_SETUP: 1 cycle.
  - DATA_STROBE: `PULSE` cycles.
  - DATA_HOLD: 1 cycle.
  - `a_d` = 0.
  - Writes: `wr_n` low during strobe, `ad_oe` = 1, `ad_out` = the data byte.
  - Reads: `rd_n` low during strobe, `ad_oe` = 0. `ad_in` is captured into its `dato_out` byte at the final DATA_STROBE edge.
- Bus framing:
  - `cs_n` is low from ADDR_SETUP through DATA_HOLD of each byte.
  - GAP is 1 cycle with `cs_n` high, between bytes only.
- After the last DATA_HOLD the machine enters DONE for 1 cycle, with `sync` = 1. It then goes to WAIT_REL and stays there until `Status3bit` == 000, then returns to IDLE.
- Writes leave `dato_out` unchanged.

## Timing
- Reset values: `sync`=0, `busy`=0, `dato_out`=0, `ad_out`=0, `ad_oe`=0, `cs_n`=1, `rd_n`=1, `wr_n`=1, `a_d`=0, `bcd_err`=0; state = IDLE.
- Acceptance edge = cycle 0. Bus activity occupies cycles 1..L, with L = N·(2·`PULSE`+4) + (N−1), where N is the number of bytes.
- `sync` is high during cycle L+1.
  - With `PULSE`=4 and a 3-byte command: L = 38, `sync` at cycle 39.
  - With `PULSE`=4 and command 111: L = 12, `sync` at cycle 13.
- Strobes never overlap.
- `ad_oe` only changes in SETUP cycles or while `cs_n` is high.
- If `Status3bit` drops to 000 mid-transaction, the transaction still completes. WAIT_REL then lasts 0 cycles: the machine is in IDLE in cycle L+2.
- If `Status3bit` holds the same nonzero value after `sync`, the command is not re-executed.
- If `resetM` is asserted in any state, all outputs take their reset values at that edge. There is no bus recovery sequence.
- `resetM` has priority over command acceptance on the same edge.

## Configuration
- `RTC_BCD_CHECK_EN` defined:
  - On each read byte capture, `bcd_err` is set if either nibble is greater than 9.
  - `bcd_err` is cleared on acceptance of the next command.
- `RTC_BCD_CHECK_EN` undefined: `bcd_err` is constant 0 and the check logic is absent.

## Test plan
- Reset 10 cycles, then `Status3bit` = 000 for 50 cycles -> all outputs stay at their reset values; `cs_n`, `rd_n`, `wr_n` stay 1.
- `Status3bit` = 100 with `dato_in` = 24'h110001 -> the bus shows:
  - address 21h, then data 01h;
  - address 22h, then data 00h;
  - address 23h, then data 11h;
  - `sync` pulses at cycle 39 only.
- `Status3bit` = 001 with a bus model returning 45h, 30h, 12h -> `dato_out` = 24'h123045 at `sync`; `ad_oe` = 0 during every read strobe.
- `Status3bit` = 111 held for 100 cycles -> exactly one address F0h / data F0h write; `sync` at cycle 13; no second transaction before `Status3bit` returns to 000.
- `resetM` pulsed at cycle 20 of a date read -> all outputs at their reset values the next cycle; a subsequent command 010 runs normally.
- With `RTC_BCD_CHECK_EN` defined, a read returning 3Ah -> `bcd_err` = 1 after `sync`; it clears on the next acceptance.
